// File: rtl/hbus_arb.sv
// ============================================================================
// Module   : hbus_arb
// Brief    : Round-robin shared-memory arbiter for NHARTS hart L2 ports, with
//            write-invalidate broadcast and a single AMO lock.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef HMEM_LINE
`define HMEM_LINE 512
`endif

`default_nettype none

module hbus_arb #(
    parameter int NHARTS = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NHARTS*64-1:0]           h_addr,
    input  logic [NHARTS-1:0]              h_rd,
    input  logic [NHARTS-1:0]              h_wr,
    input  logic [NHARTS*`HMEM_LINE-1:0]   h_data_out,
    output logic [NHARTS*`HMEM_LINE-1:0]   h_data_in,
    output logic [NHARTS-1:0]              h_dv,
    output logic [NHARTS-1:0]              h_inv,
    output logic [63:0]                    h_inv_addr,
    input  logic [NHARTS-1:0]              h_amo_req,
    output logic [NHARTS-1:0]              h_amo_ack,
    output logic [63:0]                    m_addr,
    output logic                           m_rd,
    output logic                           m_wr,
    output logic [`HMEM_LINE-1:0]          m_data_out,
    input  logic [`HMEM_LINE-1:0]          m_data_in,
    input  logic                           m_dv
);

    localparam int c_LINE_W = `HMEM_LINE;
    localparam int c_PTR_W  = (NHARTS > 1) ? $clog2(NHARTS) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [c_PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [c_PTR_W-1:0]           gnt_q, gnt_d;
    logic                         m_rd_q, m_rd_d;
    logic                         m_wr_q, m_wr_d;
    logic [63:0]                  m_addr_q, m_addr_d;
    logic [c_LINE_W-1:0]          m_data_q, m_data_d;
    logic [NHARTS-1:0]            h_dv_q, h_dv_d;
    logic [NHARTS-1:0]            h_inv_q, h_inv_d;
    logic [63:0]                  h_inv_addr_q, h_inv_addr_d;
    logic [NHARTS*c_LINE_W-1:0]   h_data_in_q, h_data_in_d;
    logic [NHARTS-1:0]            amo_ack_q, amo_ack_d;

    logic [NHARTS-1:0]            w_elig;
    logic                         w_gnt_vld;
    logic [c_PTR_W-1:0]           w_gnt_idx;

    // While the lock is held only its owner may reach memory.
    assign w_elig = (h_rd | h_wr) & ((|amo_ack_q) ? amo_ack_q : {NHARTS{1'b1}});

    // Round-robin: first eligible at or above rr_ptr, else first below it.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NHARTS; i++) begin
            if (!w_gnt_vld && w_elig[i] && (i >= int'(rr_ptr_q))) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = c_PTR_W'(i);
            end
        end
        for (int i = 0; i < NHARTS; i++) begin
            if (!w_gnt_vld && w_elig[i] && (i < int'(rr_ptr_q))) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = c_PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= c_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_gnt_vld) state_d = c_BUSY;
            c_BUSY:  if (m_dv)      state_d = c_DONE;
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        m_rd_d       = m_rd_q;
        m_wr_d       = m_wr_q;
        m_addr_d     = m_addr_q;
        m_data_d     = m_data_q;
        h_dv_d       = '0;
        h_inv_d      = '0;
        h_inv_addr_d = h_inv_addr_q;
        h_data_in_d  = h_data_in_q;
        amo_ack_d    = amo_ack_q & h_amo_req;

        case (state_q)
            c_IDLE: begin
                if (w_gnt_vld) begin
                    gnt_d    = w_gnt_idx;
                    m_addr_d = h_addr[int'(w_gnt_idx)*64 +: 64];
                    // A hart asserting both strobes gets its write first.
                    if (h_wr[w_gnt_idx]) begin
                        m_wr_d   = 1'b1;
                        m_data_d = h_data_out[int'(w_gnt_idx)*c_LINE_W +: c_LINE_W];
                    end else begin
                        m_rd_d = 1'b1;
                    end
                    rr_ptr_d = (int'(w_gnt_idx) == NHARTS - 1) ? '0
                                                               : w_gnt_idx + c_PTR_W'(1);
                end else if (!(|amo_ack_q) && (|h_amo_req)) begin
                    amo_ack_d = h_amo_req & (~h_amo_req + NHARTS'(1));
                end
            end
            c_BUSY: begin
                if (m_dv) begin
                    m_rd_d = 1'b0;
                    m_wr_d = 1'b0;
                    h_dv_d = NHARTS'(1) << gnt_q;
                    if (m_rd_q) begin
                        h_data_in_d[int'(gnt_q)*c_LINE_W +: c_LINE_W] = m_data_in;
                    end else begin
                        h_inv_d      = ~(NHARTS'(1) << gnt_q);
                        h_inv_addr_d = m_addr_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            m_rd_q       <= 1'b0;
            m_wr_q       <= 1'b0;
            m_addr_q     <= '0;
            m_data_q     <= '0;
            h_dv_q       <= '0;
            h_inv_q      <= '0;
            h_inv_addr_q <= '0;
            h_data_in_q  <= '0;
            amo_ack_q    <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            m_rd_q       <= m_rd_d;
            m_wr_q       <= m_wr_d;
            m_addr_q     <= m_addr_d;
            m_data_q     <= m_data_d;
            h_dv_q       <= h_dv_d;
            h_inv_q      <= h_inv_d;
            h_inv_addr_q <= h_inv_addr_d;
            h_data_in_q  <= h_data_in_d;
            amo_ack_q    <= amo_ack_d;
        end
    end

    assign m_rd       = m_rd_q;
    assign m_wr       = m_wr_q;
    assign m_addr     = m_addr_q;
    assign m_data_out = m_data_q;
    assign h_dv       = h_dv_q;
    assign h_inv      = h_inv_q;
    assign h_inv_addr = h_inv_addr_q;
    assign h_data_in  = h_data_in_q;
    assign h_amo_ack  = amo_ack_q;

endmodule

`default_nettype wire
